// File: rtl/uart_par_pkg.sv
// Shared types and parity helpers for the UART parity unit (TX generator and RX checker).
package uart_par_pkg;

  localparam int unsigned MAX_DATA_W = 9;
  localparam int unsigned LEN_FN_W   = 4;
  localparam int unsigned MIN_LEN    = 5;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    PAR  = 2'b10
  } rx_state_e;

  // Parity bit over the low 'len' bits of 'data' for the given mode.
  function automatic logic par_calc(input logic [MAX_DATA_W-1:0] data,
                                    input logic [LEN_FN_W-1:0]   len,
                                    input par_mode_e             mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < int'(len)) x = x ^ data[i];
    end
    case (mode)
      PAR_EVEN:  par_calc = x;
      PAR_ODD:   par_calc = ~x;
      PAR_MARK:  par_calc = 1'b1;
      default:   par_calc = 1'b0;
    endcase
  endfunction

  // Out-of-range lengths fall back to the full data width.
  function automatic logic [LEN_FN_W-1:0] len_clamp(input logic [LEN_FN_W-1:0] len,
                                                    input logic [LEN_FN_W-1:0] max_len);
    if ((len < LEN_FN_W'(MIN_LEN)) || (len > max_len)) len_clamp = max_len;
    else                                                len_clamp = len;
  endfunction

endpackage

// File: rtl/uart_parity_unit_if.sv
// TX parity handshake bundle: word in (valid/ready), parity result out (valid/ack).
interface uart_parity_unit_if #(
  parameter int unsigned DATA_W = 8
);
  logic              i_tx_valid;
  logic [DATA_W-1:0] i_tx_data;
  logic              o_tx_ready;
  logic              o_tx_par_valid;
  logic              o_tx_par_bit;
  logic              i_tx_par_ack;

  modport master (
    output i_tx_valid, i_tx_data, i_tx_par_ack,
    input  o_tx_ready, o_tx_par_valid, o_tx_par_bit
  );

  modport slave (
    input  i_tx_valid, i_tx_data, i_tx_par_ack,
    output o_tx_ready, o_tx_par_valid, o_tx_par_bit
  );
endinterface

// File: rtl/uart_par_rx_chk.sv
// RX parity checker: bit-serial accumulation, parity compare, error flag and
// saturating error counter. Counter present only when UART_PAR_ERR_CNT_EN is defined.
module uart_par_rx_chk
  import uart_par_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEN_W     = $clog2(DATA_W + 1),
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_par_en,
  input  logic [1:0]           i_cfg_par_mode,
  input  logic [LEN_W-1:0]     i_cfg_len,
  input  logic                 i_rx_start,
  input  logic                 i_rx_bit_valid,
  input  logic                 i_rx_bit,
  input  logic                 i_err_cnt_clr,
  output logic                 o_rx_par_done,
  output logic                 o_rx_par_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  rx_state_e        r_state;
  par_mode_e        r_mode;
  logic             r_en;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_done;
  logic             r_err;

  logic [LEN_W-1:0] w_cfg_len;
  logic             w_last_bit;
  logic             w_par_exp;

  assign w_cfg_len  = LEN_W'(len_clamp(LEN_FN_W'(i_cfg_len), LEN_FN_W'(DATA_W)));
  assign w_last_bit = (r_cnt == (r_len - LEN_W'(1)));
  assign w_par_exp  = par_calc(MAX_DATA_W'(r_acc), LEN_FN_W'(1), r_mode);

  // Frame FSM; a start pulse in any state (re)opens a frame with fresh config.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_mode  <= PAR_EVEN;
      r_en    <= 1'b0;
      r_len   <= LEN_W'(DATA_W);
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_rx_start) begin
        r_state <= DATA;
        r_mode  <= par_mode_e'(i_cfg_par_mode);
        r_en    <= i_cfg_par_en;
        r_len   <= w_cfg_len;
        r_cnt   <= '0;
        r_acc   <= 1'b0;
      end else begin
        case (r_state)
          DATA: begin
            if (i_rx_bit_valid) begin
              r_acc <= r_acc ^ i_rx_bit;
              r_cnt <= r_cnt + LEN_W'(1);
              if (w_last_bit) begin
                if (r_en) begin
                  r_state <= PAR;
                end else begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= IDLE;
                end
              end
            end
          end
          PAR: begin
            if (i_rx_bit_valid) begin
              r_done  <= 1'b1;
              r_err   <= (i_rx_bit != w_par_exp);
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_rx_par_done = r_done;
  assign o_rx_par_err  = r_err;

`ifdef UART_PAR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating error count; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (r_done && r_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr = i_err_cnt_clr;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: rtl/uart_parity_unit.sv
// UART parity unit top: TX parity result register with valid/ready/ack handshake,
// plus the RX parity checker. Error counter gated by UART_PAR_ERR_CNT_EN.
module uart_parity_unit
  import uart_par_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEN_W     = $clog2(DATA_W + 1),
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_par_en,
  input  logic [1:0]           i_cfg_par_mode,
  input  logic [LEN_W-1:0]     i_cfg_len,
  uart_parity_unit_if.slave    tx_if,
  input  logic                 i_rx_start,
  input  logic                 i_rx_bit_valid,
  input  logic                 i_rx_bit,
  output logic                 o_rx_par_done,
  output logic                 o_rx_par_err,
  input  logic                 i_err_cnt_clr,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  logic r_tx_par_valid;
  logic r_tx_par_bit;

  logic w_tx_ready;
  logic w_tx_accept;
  logic w_tx_par;

  assign w_tx_ready  = !r_tx_par_valid || tx_if.i_tx_par_ack;
  assign w_tx_accept = tx_if.i_tx_valid && w_tx_ready;
  assign w_tx_par    = i_cfg_par_en &&
                       par_calc(MAX_DATA_W'(tx_if.i_tx_data),
                                len_clamp(LEN_FN_W'(i_cfg_len), LEN_FN_W'(DATA_W)),
                                par_mode_e'(i_cfg_par_mode));

  // Result register: loads on accept (ack + accept reloads with no bubble), drops on ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_par_valid <= 1'b0;
      r_tx_par_bit   <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_par_valid <= 1'b1;
      r_tx_par_bit   <= w_tx_par;
    end else if (tx_if.i_tx_par_ack) begin
      r_tx_par_valid <= 1'b0;
    end
  end

  assign tx_if.o_tx_ready     = w_tx_ready;
  assign tx_if.o_tx_par_valid = r_tx_par_valid;
  assign tx_if.o_tx_par_bit   = r_tx_par_bit;

  uart_par_rx_chk #(
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_rx_chk (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cfg_par_en   (i_cfg_par_en),
    .i_cfg_par_mode (i_cfg_par_mode),
    .i_cfg_len      (i_cfg_len),
    .i_rx_start     (i_rx_start),
    .i_rx_bit_valid (i_rx_bit_valid),
    .i_rx_bit       (i_rx_bit),
    .i_err_cnt_clr  (i_err_cnt_clr),
    .o_rx_par_done  (o_rx_par_done),
    .o_rx_par_err   (o_rx_par_err),
    .o_err_cnt      (o_err_cnt)
  );

endmodule

// File: tb/tb_uart_parity_unit.sv
// Directed bench for uart_parity_unit with TX/RX scoreboard queues and an
// independent parity / error-counter model.
module tb_uart_parity_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          par_en;
  logic [1:0]    par_mode;
  logic [LW-1:0] cfg_len;
  logic          rx_start;
  logic          rx_bit_valid;
  logic          rx_bit;
  logic          cnt_clr;
  logic          rx_done;
  logic          rx_err;
  logic [CW-1:0] err_cnt;

  uart_parity_unit_if #(.DATA_W(DW)) tx_if ();

  uart_parity_unit #(.DATA_W(DW), .LEN_W(LW), .ERR_CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cfg_par_en   (par_en),
    .i_cfg_par_mode (par_mode),
    .i_cfg_len      (cfg_len),
    .tx_if          (tx_if),
    .i_rx_start     (rx_start),
    .i_rx_bit_valid (rx_bit_valid),
    .i_rx_bit       (rx_bit),
    .o_rx_par_done  (rx_done),
    .o_rx_par_err   (rx_err),
    .i_err_cnt_clr  (cnt_clr),
    .o_err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit tx_q[$];
  bit rx_q[$];
  bit rx_last     = 1'b0;
  bit rx_last_err = 1'b0;
  bit m_err       = 1'b0;
  bit m_done_now  = 1'b0;
  bit m_done_err  = 1'b0;
  int m_cnt       = 0;

  function automatic int eff_len(input logic [LW-1:0] len);
    if (len < 5 || len > DW) return DW;
    return int'(len);
  endfunction

  function automatic bit model_par(input logic [DW-1:0] d, input logic [LW-1:0] len,
                                   input bit en, input logic [1:0] mode);
    bit x;
    x = 1'b0;
    for (int i = 0; i < eff_len(len); i++) x = x ^ d[i];
    if (!en) return 1'b0;
    case (mode)
      2'd0:    return x;
      2'd1:    return !x;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs about to be sampled, then check outputs.
  task automatic step();
    bit consume;
    bit accept;
    bit e;
    consume = (tx_q.size() > 0) && tx_if.i_tx_par_ack;
    accept  = tx_if.i_tx_valid && ((tx_q.size() == 0) || tx_if.i_tx_par_ack);
`ifdef UART_PAR_ERR_CNT_EN
    if (rst || cnt_clr) m_cnt = 0;
    else if (m_done_now && m_done_err && m_cnt < 3) m_cnt++;
`endif
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_err      = 1'b0;
      m_done_now = 1'b0;
      m_done_err = 1'b0;
    end else begin
      if (consume) void'(tx_q.pop_front());
      if (accept) tx_q.push_back(model_par(tx_if.i_tx_data, cfg_len, par_en, par_mode));
      m_done_now = rx_last;
      m_done_err = rx_last_err;
      if (rx_last) m_err = rx_last_err;
    end
    rx_last = 1'b0;
    @(posedge clk);
    #1;
    chk("tx_par_valid", 32'(tx_if.o_tx_par_valid), 32'(tx_q.size() > 0));
    if (tx_q.size() > 0) chk("tx_par_bit", 32'(tx_if.o_tx_par_bit), 32'(tx_q[0]));
    chk("tx_ready", 32'(tx_if.o_tx_ready), 32'((tx_q.size() == 0) || tx_if.i_tx_par_ack));
    chk("rx_done", 32'(rx_done), 32'(m_done_now));
    if (rx_done) begin
      chk("rx_q_nonempty_at_done", 32'(rx_q.size() > 0), 32'd1);
      if (rx_q.size() > 0) begin
        e = rx_q.pop_front();
        chk("rx_err_at_done", 32'(rx_err), 32'(e));
      end
    end
    chk("rx_err_hold", 32'(rx_err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  task automatic tx_word(input logic [DW-1:0] d, input int hold);
    tx_if.i_tx_valid = 1'b1;
    tx_if.i_tx_data  = d;
    step();
    tx_if.i_tx_valid = 1'b0;
    tx_if.i_tx_data  = ~d;
    repeat (hold) step();
    tx_if.i_tx_par_ack = 1'b1;
    step();
    tx_if.i_tx_par_ack = 1'b0;
  endtask

  task automatic rx_send(input bit b, input bit last, input bit exp_err);
    rx_bit_valid = 1'b1;
    rx_bit       = b;
    if (last) begin
      rx_last     = 1'b1;
      rx_last_err = exp_err;
      rx_q.push_back(exp_err);
    end
    step();
    rx_bit_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [DW-1:0] d, input bit flip);
    int l;
    bit p;
    l = eff_len(cfg_len);
    p = model_par(d, cfg_len, par_en, par_mode) ^ flip;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < l; i++) begin
      rx_send(d[i], (i == l - 1) && !par_en, 1'b0);
      if (i == 2) step();
    end
    if (par_en) rx_send(p, 1'b1, flip);
  endtask

  initial begin
    rst                = 1'b1;
    par_en             = 1'b1;
    par_mode           = 2'd0;
    cfg_len            = 4'd8;
    rx_start           = 1'b0;
    rx_bit_valid       = 1'b0;
    rx_bit             = 1'b0;
    cnt_clr            = 1'b0;
    tx_if.i_tx_valid   = 1'b0;
    tx_if.i_tx_data    = '0;
    tx_if.i_tx_par_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // TX parity modes and lengths
    tx_word(8'hA5, 2);
    par_mode = 2'd1; tx_word(8'hA5, 1);
    par_mode = 2'd0; cfg_len = 4'd7; tx_word(8'h81, 1);
    par_mode = 2'd2; tx_word(8'h81, 0);
    par_mode = 2'd3; tx_word(8'h81, 0);
    par_mode = 2'd0; cfg_len = 4'd3; tx_word(8'h81, 0);
    cfg_len = 4'd5; tx_word(8'h31, 0);
    par_en = 1'b0; cfg_len = 4'd8; tx_word(8'h01, 1);
    par_en = 1'b1;

    // TX back-to-back with ack tied high, then stall with ack low
    tx_if.i_tx_par_ack = 1'b1;
    tx_if.i_tx_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_if.i_tx_data = DW'(8'h13 * (i + 1));
      par_mode        = 2'(i);
      step();
    end
    tx_if.i_tx_par_ack = 1'b0;
    tx_if.i_tx_data    = 8'h77;
    repeat (3) step();
    tx_if.i_tx_valid   = 1'b0;
    tx_if.i_tx_par_ack = 1'b1;
    step();
    tx_if.i_tx_par_ack = 1'b0;
    step();

    // RX: bad then good frame, even, len 8
    par_mode = 2'd0; cfg_len = 4'd8;
    rx_frame(8'hA5, 1'b1);
    step();
    rx_frame(8'hA5, 1'b0);
    step();

    // RX: bits in IDLE are ignored
    rx_send(1'b1, 1'b0, 1'b0);
    rx_send(1'b0, 1'b0, 1'b0);

    // RX abort then full correct frame; config change mid-frame must not matter
    rx_start = 1'b1; step(); rx_start = 1'b0;
    for (int i = 0; i < 4; i++) rx_send(1'b1, 1'b0, 1'b0);
    par_mode = 2'd1;
    rx_frame(8'h3C, 1'b0);
    step();

    // RX: odd/mark modes, disabled parity, short and clamped lengths
    rx_frame(8'h5B, 1'b1);
    par_mode = 2'd2; rx_frame(8'h00, 1'b0);
    par_en = 1'b0; cfg_len = 4'd5; rx_frame(8'h1F, 1'b0);
    par_en = 1'b1; par_mode = 2'd0; cfg_len = 4'd3; rx_frame(8'hF1, 1'b0);
    step();

    // Counter saturation, then clear in the same cycle as a bad-frame done
    cfg_len = 4'd8;
    for (int i = 0; i < 5; i++) rx_frame(DW'(8'h21 * (i + 1)), 1'b1);
    step();
    rx_frame(8'h66, 1'b1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    step();
    rx_frame(8'h0F, 1'b1);
    step();
    step();

    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    chk("rx_q_drained", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_parity_unit.md
Name: uart_parity_unit

Overview:
Parametrised parity engine for the UART datapath, successor to the fixed 8-bit TX parity register.
- TX side: generates the parity bit for a parallel word through a valid/ready handshake.
- RX side: accumulates parity bit-serially, checks the received parity bit, flags errors and counts them.
- Supports runtime data length and five parity modes (none, even, odd, mark, space).

Parameters:
- DATA_W, 8, maximum data bits per frame; legal 5..9.
- LEN_W, $clog2(DATA_W+1), width of the length config field.
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_cfg_par_en  in  1  1 = parity enabled.
- i_cfg_par_mode  in  2  00 even, 01 odd, 10 mark, 11 space.
- i_cfg_len  in  LEN_W  number of data bits, 5..DATA_W.
- i_tx_valid  in  1  TX word valid.
- i_tx_data  in  DATA_W  TX word, LSB first; bits at and above i_cfg_len ignored.
- o_tx_ready  out  1  TX word can be accepted.
- o_tx_par_valid  out  1  TX parity result valid.
- o_tx_par_bit  out  1  TX parity bit.
- i_tx_par_ack  in  1  consumer took the TX result.
- i_rx_start  in  1  start-of-frame pulse (start bit detected).
- i_rx_bit_valid  in  1  one sampled RX bit present.
- i_rx_bit  in  1  sampled RX bit value.
- o_rx_par_done  out  1  one-cycle pulse at end of checked frame.
- o_rx_par_err  out  1  parity mismatch on last frame.
- i_err_cnt_clr  in  1  clear the error counter.
- o_err_cnt  out  ERR_CNT_W  saturating count of parity errors.

Behaviour:
- Reset (sync, i_rst=1) forces all outputs to 0 except o_tx_ready=1. RX FSM goes to IDLE and the accumulator and counter clear.
- Parity function: x = XOR of i_tx_data[i] for i < cfg_len. Even → x; odd → ~x; mark → 1; space → 0.
- TX path:
  - A transfer is accepted when i_tx_valid & o_tx_ready.
  - Config is sampled at acceptance.
  - The next cycle gives o_tx_par_valid=1 with o_tx_par_bit; latency is 1 cycle.
  - The result is held stable until i_tx_par_ack.
  - o_tx_ready = !o_tx_par_valid | i_tx_par_ack. An ack and a new accept in the same cycle load the new result with no bubble.
  - With parity disabled, words are still accepted and o_tx_par_valid still asserts, with o_tx_par_bit=0. The consumer ignores the bit.
- RX FSM, states IDLE, DATA, PAR:
  - IDLE: i_rx_start → DATA. Config is latched, acc=0, cnt=0.
  - DATA: on each i_rx_bit_valid, acc ^= i_rx_bit and cnt++. When cnt == len-1 on a valid bit:
    - If parity is enabled, go to PAR.
    - Otherwise pulse o_rx_par_done the next cycle with o_rx_par_err=0, and return to IDLE.
  - PAR: the next i_rx_bit_valid is the parity bit. It is compared with the expected value computed from acc per the latched mode. The next cycle gives an o_rx_par_done pulse, o_rx_par_err = mismatch, and return to IDLE.
  - o_rx_par_err holds until the next o_rx_par_done or reset.
  - i_rx_start in DATA or PAR aborts the frame and restarts DATA. There is no done pulse and o_rx_par_err is unchanged.
  - i_rx_bit_valid in IDLE is ignored.
  - Config changes mid-frame have no effect until the next start.
- Error counter:
  - Increments on each done with err=1 and saturates at all-ones.
  - i_err_cnt_clr takes priority over an increment in the same cycle.
- Illegal i_cfg_len (<5 or >DATA_W) is clamped to DATA_W at latch time.

Optional Feature:
UART_PAR_ERR_CNT_EN
- Defined: the error counter, i_err_cnt_clr and o_err_cnt are active as described.
- Undefined: the counter logic is removed, o_err_cnt is tied to 0 and i_err_cnt_clr is ignored. All other behaviour is identical.

Decomposition:
- Package uart_par_pkg holds:
  - par_mode_e enum (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE).
  - rx_state_e enum (IDLE, DATA, PAR).
  - constants MIN_LEN=5.
  - function par_calc(data, len, mode) returning the parity bit, shared by TX and RX.
- One sub-module, uart_par_rx_chk: the RX FSM, accumulator and error counter. The top level holds the TX handshake register and instantiates uart_par_rx_chk.

Test Plan:
- TX even, len=8, data=0xA5 → o_tx_par_bit=0 one cycle after accept. Odd with the same data → 1.
- TX len=7, even, data=0x81 → bit 7 ignored, parity=1. With mark mode → 1; with space mode → 0.
- TX back-to-back: valid held with ack tied high → o_tx_ready stays 1 and a new result appears every cycle. With ack low → ready=0 and the result is stable.
- RX even, len=8, bits of 0xA5 then parity bit 1 → o_rx_par_done pulse, o_rx_par_err=1, o_err_cnt 0→1. A second frame with correct parity 0 → err=0 and count stays 1.
- RX abort: start, 4 data bits, start again, then a full correct frame → exactly one done pulse with err=0.
- Counter: with ERR_CNT_W=2, drive 5 bad frames → o_err_cnt saturates at 3. Assert clear in the same cycle as a bad-frame done → count=0.
